// File: rtl/data_mem_responder.sv
// Multi-cycle single-port data memory behind the memory-stage interface.
// One request in flight; Stall while busy, one-cycle Done on completion, Err for bad requests.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Halt,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        Err
);

  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [15:0]             dout_q, dout_d;
  logic [15:0]             mem_q [0:DEPTH-1];

  logic                    accept_s;
  logic                    reject_s;
  logic                    commit_s;
  logic                    commit_wr_s;
  logic                    mem_we_s;
  logic [DEPTH_LOG2-1:0]   mem_idx_s;
  logic [15:0]             mem_wdata_s;
  logic                    addr_unused;

  assign addr_unused = ^Addr[15:DEPTH_LOG2+1];

  // Next-state, latching and commit control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    dout_d      = dout_q;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    commit_s    = 1'b0;
    commit_wr_s = op_wr_q;
    mem_we_s    = 1'b0;
    mem_idx_s   = idx_q;
    mem_wdata_s = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (!Halt && (Rd || Wr)) begin
          if ((Rd ^ Wr) && !Addr[0]) begin
            accept_s = 1'b1;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          accept_s = 1'b0;
        end
        if (accept_s) begin
          op_wr_d     = Wr;
          idx_d       = Addr[DEPTH_LOG2:1];
          wdata_d     = DataIn;
          // With single-cycle latency the commit edge is the acceptance edge, so use live inputs
          commit_wr_s = Wr;
          mem_idx_s   = Addr[DEPTH_LOG2:1];
          mem_wdata_s = DataIn;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d  = S_RESP;
            cnt_d    = 4'd0;
            commit_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d  = S_RESP;
          cnt_d    = 4'd0;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (commit_s) begin
      if (commit_wr_s) begin
        mem_we_s = 1'b1;
      end else begin
        dout_d = mem_q[mem_idx_s];
      end
    end else begin
      mem_we_s = 1'b0;
    end
  end

  assign Stall   = accept_s || (state_q == S_WAIT);
  assign Done    = (state_q == S_RESP);
  assign Err     = reject_s;
  assign DataOut = dout_q;

  // Control and read-data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 16'd0;
      dout_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
    end
  end

  // Storage keeps its contents across reset; a reset edge suppresses a pending commit
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      mem_q[mem_idx_s] <= mem_wdata_s;
    end
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder sitting on the far side of the processor's memory-stage interface. It accepts one word read or write request at a time from the pipeline and holds `Stall` high while the access is in flight. It completes the access after a fixed, parameterised latency and signals completion with a one-cycle `Done` pulse, returning read data on `DataOut`. Illegal requests are rejected with an `Err` pulse and no memory access.

## Interface
- `DEPTH_LOG2`, 8: log2 of storage depth in 16-bit words (256 words).
- `LATENCY`, 4: cycles from the acceptance cycle to the `Done` cycle; legal range 1..15.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-low.
- `Rd`  in  1  read request.
- `Wr`  in  1  write request.
- `Addr`  in  16  byte address; word index is `Addr[DEPTH_LOG2:1]`.
- `DataIn`  in  16  write data.
- `Halt`  in  1  when high, no new request is accepted; an in-flight access still completes.
- `DataOut`  out  16  read data; valid in the `Done` cycle of a read, then held.
- `Stall`  out  1  initiator must hold the pipeline (and the request) while high.
- `Done`  out  1  one-cycle completion pulse.
- `Err`  out  1  one-cycle pulse for a rejected request.

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- Legal request in IDLE: exactly one of `Rd`/`Wr` high, `Addr[0]==0`, `Halt==0`.
  - Latch op, word index, `DataIn`.
  - `Stall`=1 combinationally in that same cycle.
  - Next state: WAIT if `LATENCY>1`, else RESP.
- Illegal request in IDLE (`Rd&Wr`, or `Addr[0]==1` with `Rd|Wr`), `Halt==0`:
  - `Err`=1 that cycle, combinational.
  - No stall, no access, state stays IDLE.
- WAIT: `Stall`=1.
  - Internal down-counter is loaded at acceptance and decrements each cycle.
  - Leaves WAIT for RESP on the edge that completes `LATENCY-1` cycles after acceptance.
  - Request inputs are ignored; latched copies are used.
- Edge entering RESP:
  - A write commits `mem[idx] <= data`.
  - A read registers `DataOut <= mem[idx]`.
- RESP: `Done`=1, `Stall`=0. Next state is always IDLE.
  - The request still presented on the inputs during RESP is the completed one and is never re-accepted.
- `DataOut` holds its value until the next read completes. Writes do not change it.
- Address bits above `DEPTH_LOG2` are ignored, so addresses alias modulo the storage depth.
- `Halt` high in IDLE blocks acceptance and suppresses `Err`. `Halt` in WAIT/RESP has no effect.
- Storage contents are not cleared by reset.

## Timing
- Reset (`rst`==0 at an edge): state IDLE, counter 0, `DataOut`=0, `Stall`=0, `Done`=0, `Err`=0.
  - A pending uncommitted write is discarded.
  - Reset overrides every other event in the same cycle.
- Acceptance in cycle T:
  - `Stall` is high in cycles T..T+LATENCY-1.
  - `Done` is high in cycle T+LATENCY.
  - The earliest next acceptance is cycle T+LATENCY+1.
- `LATENCY`=1: `Stall` is high only in cycle T; `Done` is high in cycle T+1.
- `Done` and `Stall` are never high in the same cycle. `Err` is never high while `Stall` is high.
- Storage is a single-port model. Only one access is outstanding, so there is no read/write collision.

## Test plan
1. Reset, then Wr `Addr`=0x0010, `DataIn`=0xBEEF, `LATENCY`=4 -> `Stall` high for 4 cycles, `Done` in the 5th cycle. Then Rd 0x0010 -> `DataOut`=0xBEEF in its `Done` cycle.
2. Request held through the RESP cycle and beyond -> exactly one access per acceptance. A second `Done` only follows a fresh IDLE acceptance; RESP cycles are never followed by a re-acceptance in the same cycle.
3. Rd with `Addr`=0x0011, and Rd&Wr together -> `Err` pulse, `Stall`=0, no `Done`. A following Rd 0x0010 still returns 0xBEEF.
4. Wr 0x0002 with 0x1234, then Rd 0x0202 (`DEPTH_LOG2`=8) -> 0x1234 (alias). Subsequent Wr 0x0004 leaves `DataOut` at 0x1234.
5. `rst` low during WAIT of a Wr 0x0020 with 0x5555 -> next cycle all outputs 0, state IDLE. A later Rd 0x0020 returns the prior contents, not 0x5555.
6. `Halt` high with a pending Rd in IDLE -> no `Stall`, `Done` or `Err`. `Halt` raised mid-WAIT -> `Done` still occurs at T+LATENCY. Repeat test 1 with `LATENCY`=1: `Stall` lasts 1 cycle, `Done` at T+1.
